// File: rtl/opnd_mem_seq_pkg.sv
// Shared definitions for the operand memory sequencer: state encoding,
// timeout default, operand destination codes, the latched descriptor type
// and the small combinational helpers that steer the state machine.
package opnd_mem_seq_pkg;

   // Default for the ack wait limit (legal range 1..255).
   localparam int TIMEOUT_DEFAULT = 255;

   // Sequencer states.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD0  = 3'd1;
   localparam logic [2:0] ST_RD1  = 3'd2;
   localparam logic [2:0] ST_EXEC = 3'd3;
   localparam logic [2:0] ST_WR0  = 3'd4;
   localparam logic [2:0] ST_WR1  = 3'd5;
   localparam logic [2:0] ST_FIN  = 3'd6;

   // Which operand a memory access belongs to.
   localparam logic OPND_DEST_0 = 1'b0;
   localparam logic OPND_DEST_1 = 1'b1;

   // Operand descriptor captured when a request is accepted.
   typedef struct packed {
      logic        rd0;
      logic        wr0;
      logic        rd1;
      logic        wr1;
      logic [31:0] addr0;
      logic [31:0] addr1;
   } opnd_desc_t;

   // Address-equality compare used for read merging and write collapsing.
   function automatic logic addr_eq(input logic [31:0] a, input logic [31:0] b);
      return (a == b);
   endfunction

   // Both operands read the same word: one read serves both.
   function automatic logic dup_read(input opnd_desc_t d);
      return d.rd0 && d.rd1 && addr_eq(d.addr0, d.addr1);
   endfunction

   // Both operands write the same word: only operand 1's write is issued.
   function automatic logic dup_write(input opnd_desc_t d);
      return d.wr0 && d.wr1 && addr_eq(d.addr0, d.addr1);
   endfunction

   // First state after a request is accepted.
   function automatic logic [2:0] state_after_start(input opnd_desc_t d);
      logic [2:0] st;
      if (d.rd0)      st = ST_RD0;
      else if (d.rd1) st = ST_RD1;
      else            st = ST_EXEC;
      return st;
   endfunction

   // State following a completed operand-0 read.
   function automatic logic [2:0] state_after_rd0(input opnd_desc_t d);
      return (d.rd1 && !dup_read(d)) ? ST_RD1 : ST_EXEC;
   endfunction

   // State following an accepted execute result.
   function automatic logic [2:0] state_after_exec(input opnd_desc_t d);
      logic [2:0] st;
      if (d.wr0 && !dup_write(d)) st = ST_WR0;
      else if (d.wr1)             st = ST_WR1;
      else                        st = ST_FIN;
      return st;
   endfunction

   // State following a completed operand-0 write.
   function automatic logic [2:0] state_after_wr0(input opnd_desc_t d);
      return d.wr1 ? ST_WR1 : ST_FIN;
   endfunction

   // True in the states that own the memory port.
   function automatic logic is_access(input logic [2:0] st);
      return (st == ST_RD0) || (st == ST_RD1) || (st == ST_WR0) || (st == ST_WR1);
   endfunction

   function automatic logic is_write(input logic [2:0] st);
      return (st == ST_WR0) || (st == ST_WR1);
   endfunction

   // Operand targeted by the access in progress.
   function automatic logic access_opnd(input logic [2:0] st);
      return ((st == ST_RD1) || (st == ST_WR1)) ? OPND_DEST_1 : OPND_DEST_0;
   endfunction

endpackage

// File: rtl/ack_timer.sv
// Ack wait timer: counts cycles a request waits without acknowledge and
// flags the cycle in which the count reaches TIMEOUT.
module ack_timer
   import opnd_mem_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear wins over run so every new access starts from zero.
   always_comb begin
      // NOTE: assign a default first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (clear)    count_d = 8'd0;
      else if (run) count_d = count_q + 8'd1;
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      if (rst) count_q <= 8'd0;
      else     count_q <= count_d;
   end

   // This waiting cycle is the TIMEOUT-th one: the count reaches TIMEOUT at the edge.
   assign expired = run && (count_q == LAST_WAIT);

endmodule

// File: rtl/opnd_mem_seq.sv
// Operand memory sequencer: fetches up to two memory operands over one
// shared memory port, hands them to execute, then writes results back,
// with a per-access ack timeout that aborts to FIN with fault.
module opnd_mem_seq
   import opnd_mem_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        opnd0_rd,
   input  logic        opnd0_wr,
   input  logic        opnd1_rd,
   input  logic        opnd1_wr,
   input  logic [31:0] opnd0_addr,
   input  logic [31:0] opnd1_addr,
   input  logic        exec_done,
   input  logic [31:0] opnd0_wdata,
   input  logic [31:0] opnd1_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        rd_valid,
   output logic [31:0] opnd0_memval,
   output logic [31:0] opnd1_memval,
   output logic        done,
   output logic        fault
);

   logic [2:0]  state_q,   state_d;
   opnd_desc_t  desc_q,    desc_d;
   logic [31:0] wdata0_q,  wdata0_d;
   logic [31:0] wdata1_q,  wdata1_d;
   logic [31:0] memval0_q, memval0_d;
   logic [31:0] memval1_q, memval1_d;
   logic        fault_q,   fault_d;

   opnd_desc_t  desc_in;
   logic        timer_clear;
   logic        timer_run;
   logic        timer_expired;
   logic        sel_opnd1;

   assign desc_in = {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr, opnd0_addr, opnd1_addr};

   // The timer only sees acks while a request is out, so stray acks are ignored.
   assign timer_run   = mem_req && !mem_ack;
   assign timer_clear = !mem_req || mem_ack;

   ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .run     (timer_run),
      .expired (timer_expired)
   );

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d   = state_q;
      desc_d    = desc_q;
      wdata0_d  = wdata0_q;
      wdata1_d  = wdata1_q;
      memval0_d = memval0_q;
      memval1_d = memval1_q;
      fault_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               desc_d    = desc_in;
               memval0_d = 32'd0;
               memval1_d = 32'd0;
               state_d   = state_after_start(desc_in);
            end
         end
         ST_RD0: begin
            if (mem_ack) begin
               memval0_d = mem_rdata;
               // A merged read fills both operands from the one access.
               if (dup_read(desc_q)) memval1_d = mem_rdata;
               state_d = state_after_rd0(desc_q);
            end
         end
         ST_RD1: begin
            if (mem_ack) begin
               memval1_d = mem_rdata;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               wdata0_d = opnd0_wdata;
               wdata1_d = opnd1_wdata;
               state_d  = state_after_exec(desc_q);
            end
         end
         ST_WR0: begin
            if (mem_ack) state_d = state_after_wr0(desc_q);
         end
         ST_WR1: begin
            if (mem_ack) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // An expired wait abandons the access and finishes with fault.
      if (timer_expired) begin
         state_d = ST_FIN;
         fault_d = 1'b1;
      end
   end

   // Sequencer and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         desc_q    <= '0;
         wdata0_q  <= 32'd0;
         wdata1_q  <= 32'd0;
         memval0_q <= 32'd0;
         memval1_q <= 32'd0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         desc_q    <= desc_d;
         wdata0_q  <= wdata0_d;
         wdata1_q  <= wdata1_d;
         memval0_q <= memval0_d;
         memval1_q <= memval1_d;
         fault_q   <= fault_d;
      end
   end

   // Memory port is a pure decode of registered state, so it holds steady for the whole access.
   assign sel_opnd1 = (access_opnd(state_q) == OPND_DEST_1);
   assign mem_req   = is_access(state_q);
   assign mem_we    = is_write(state_q);
   assign mem_addr  = mem_req ? (sel_opnd1 ? desc_q.addr1 : desc_q.addr0) : 32'd0;
   assign mem_wdata = mem_we  ? (sel_opnd1 ? wdata1_q : wdata0_q) : 32'd0;

   assign busy         = (state_q != ST_IDLE);
   assign rd_valid     = (state_q == ST_EXEC);
   assign done         = (state_q == ST_FIN);
   assign fault        = fault_q;
   assign opnd0_memval = memval0_q;
   assign opnd1_memval = memval1_q;

endmodule

// File: tb/tb_opnd_mem_seq.sv
// Self-checking bench for opnd_mem_seq: directed scenarios plus randomized
// transactions, each checked against a transaction-level model that derives
// the expected access list, operand values, latency and fault outcome.
module tb_opnd_mem_seq;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr;
   logic [31:0] opnd0_addr, opnd1_addr;
   logic        exec_done;
   logic [31:0] opnd0_wdata, opnd1_wdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy, rd_valid, done, fault;
   logic [31:0] opnd0_memval, opnd1_memval;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   // Backing store seen by the bench's memory responder.
   logic [31:0] mem_model [logic [31:0]];

   always #5 clk = ~clk;

   opnd_mem_seq #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start),
      .opnd0_rd(opnd0_rd), .opnd0_wr(opnd0_wr), .opnd1_rd(opnd1_rd), .opnd1_wr(opnd1_wr),
      .opnd0_addr(opnd0_addr), .opnd1_addr(opnd1_addr),
      .exec_done(exec_done), .opnd0_wdata(opnd0_wdata), .opnd1_wdata(opnd1_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .rd_valid(rd_valid),
      .opnd0_memval(opnd0_memval), .opnd1_memval(opnd1_memval),
      .done(done), .fault(fault)
   );

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fail(input string tag, input string what);
      checks++;
      errors++;
      $error("FAIL %s: observed %s", tag, what);
   endtask

   function automatic logic [31:0] mem_peek(input logic [31:0] a);
      if (!mem_model.exists(a)) mem_model[a] = $urandom;
      return mem_model[a];
   endfunction

   // Run one transaction; called just after a falling edge, returns just after one.
   task automatic run_txn(input bit r0, input bit w0, input bit r1, input bit w1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int d0, input int d1, input int d2, input int d3,
                          input int edly, input bit st_exec, input bit st_fin);
      acc_t        q[$];
      acc_t        cur;
      int          dly[4];
      int          acc_i = 0, wait_c = 0, exec_c = 0, lat_exp = 1, tmo_idx = 0, d;
      bit          in_acc = 0, timed = 0, fin = 0, exec_added = 0;
      logic [31:0] wd0, wd1, mv0, mv1;

      dly = '{d0, d1, d2, d3};
      wd0 = $urandom;
      wd1 = $urandom;
      mv0 = r0 ? mem_peek(a0) : 32'd0;
      mv1 = r1 ? mem_peek(a1) : 32'd0;

      // Expected accesses in issue order.
      if (r0)                      q.push_back('{1'b0, a0, 32'd0});
      if (r1 && !(r0 && a0 == a1)) q.push_back('{1'b0, a1, 32'd0});
      if (w0 && !(w1 && a0 == a1)) q.push_back('{1'b1, a0, wd0});
      if (w1)                      q.push_back('{1'b1, a1, wd1});

      // Expected cycles from start edge to the done cycle.
      foreach (q[i]) begin
         if (q[i].we && !exec_added) begin
            lat_exp += 1 + edly;
            exec_added = 1;
         end
         if (dly[i] >= TMO) begin
            lat_exp += TMO;
            timed = 1;
            tmo_idx = i;
            break;
         end
         lat_exp += 1 + dly[i];
      end
      if (!timed && !exec_added) lat_exp += 1 + edly;

      start = 1'b1;
      {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = {r0, w0, r1, w1};
      opnd0_addr = a0;
      opnd1_addr = a1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = 4'($urandom);
      opnd0_addr = $urandom;
      opnd1_addr = $urandom;

      for (int obs = 1; obs <= 200 && !fin; obs++) begin
         mem_ack   = 1'b0;
         exec_done = 1'b0;
         start     = 1'b0;
         mem_rdata = $urandom;
         if (done) begin
            check("latency", 96'(obs), 96'(lat_exp));
            check("fault_at_done", 96'(fault), 96'(timed));
            check("req_at_done", 96'({mem_req, mem_we}), 96'(0));
            check("access_count", 96'(acc_i), 96'(timed ? tmo_idx : q.size()));
            if (!timed) check("memvals_at_done", {32'd0, opnd0_memval, opnd1_memval}, {32'd0, mv0, mv1});
            if (st_fin) begin
               start = 1'b1;
               {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = 4'b1111;
            end
            fin = 1;
         end else if (mem_req) begin
            check("busy_in_access", 96'(busy), 96'(1));
            check("fault_in_access", 96'(fault), 96'(0));
            if (!in_acc) begin
               in_acc = 1;
               wait_c = 0;
               cur = '{mem_we, mem_addr, mem_wdata};
               if (acc_i >= q.size()) begin
                  fail("extra_access", $sformatf("access to %h beyond the expected list", mem_addr));
               end else begin
                  check("acc_we", 96'(mem_we), 96'(q[acc_i].we));
                  check("acc_addr", 96'(mem_addr), 96'(q[acc_i].addr));
                  if (q[acc_i].we) check("acc_wdata", 96'(mem_wdata), 96'(q[acc_i].data));
               end
            end else begin
               check("acc_stable", {31'd0, mem_we, mem_addr, mem_wdata},
                     {31'd0, cur.we, cur.addr, cur.data});
            end
            // Result-valid noise outside execute must have no effect.
            exec_done   = 1'($urandom);
            opnd0_wdata = $urandom;
            opnd1_wdata = $urandom;
            d = (acc_i < 4) ? dly[acc_i] : 0;
            if (wait_c == d) begin
               mem_ack = 1'b1;
               if (!mem_we) mem_rdata = mem_peek(mem_addr);
               else         mem_model[mem_addr] = mem_wdata;
               in_acc = 0;
               acc_i++;
            end else begin
               wait_c++;
            end
         end else if (rd_valid) begin
            if (exec_c == 0) begin
               check("memval0", 96'(opnd0_memval), 96'(mv0));
               check("memval1", 96'(opnd1_memval), 96'(mv1));
               if (st_exec) begin
                  start = 1'b1;
                  opnd0_addr = $urandom;
                  {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = 4'b1111;
               end
            end
            if (exec_c == edly) begin
               exec_done   = 1'b1;
               opnd0_wdata = wd0;
               opnd1_wdata = wd1;
            end else begin
               opnd0_wdata = $urandom;
               opnd1_wdata = $urandom;
            end
            exec_c++;
         end else begin
            fail("phase", $sformatf("busy=%0b with no req/rd_valid/done", busy));
         end
         if (!fin) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      if (!fin) fail("done_wait", "no done within 200 cycles");

      // FIN lasts one cycle and a start during it is dropped.
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      exec_done = 1'b0;
      check("idle_after_fin", 96'({busy, mem_req, done, fault}), 96'(0));
   endtask

   function automatic int rnd_dly();
      return ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
   endfunction

   initial begin
      logic [31:0] ra0, ra1;

      rst = 1'b1;
      start = 1'b1;
      {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = 4'b1111;
      opnd0_addr = 32'h1234; opnd1_addr = 32'h5678;
      exec_done = 1'b1; opnd0_wdata = 32'd1; opnd1_wdata = 32'd2;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rst_ctrl", 96'({mem_req, mem_we, busy, rd_valid, done, fault}), 96'(0));
      check("rst_mem_port", {32'd0, mem_addr, mem_wdata}, 96'(0));
      check("rst_memvals", {32'd0, opnd0_memval, opnd1_memval}, 96'(0));
      start = 1'b0; exec_done = 1'b0; mem_ack = 1'b0;
      rst = 1'b0;

      // Single read, ack after two wait cycles, accepted on the first edge after reset.
      mem_model[32'h1000] = 32'hDEADBEEF;
      run_txn(1, 0, 0, 0, 32'h1000, 32'h0, 2, 0, 0, 0, 0, 0, 0);
      check("deadbeef", 96'(opnd0_memval), 96'(32'hDEADBEEF));

      // Two reads then two writes at distinct addresses.
      run_txn(1, 1, 1, 1, 32'h10, 32'h20, 1, 0, 2, 3, 1, 0, 0);

      // Merged read at one address.
      run_txn(1, 0, 1, 0, 32'h40, 32'h40, 3, 0, 0, 0, 2, 0, 0);
      check("merged_memvals", {32'd0, opnd0_memval, opnd1_memval},
            {32'd0, mem_model[32'h40], mem_model[32'h40]});

      // Colliding writes collapse to operand 1's write.
      run_txn(0, 1, 0, 1, 32'h80, 32'h80, 0, 0, 0, 0, 0, 0, 0);

      // No memory operands, starts during EXEC and FIN ignored.
      run_txn(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 1);

      // Timeout on a read, then on a write; then the longest wait that still succeeds.
      run_txn(1, 0, 1, 0, 32'h500, 32'h504, TMO, 0, 0, 0, 0, 0, 0);
      run_txn(0, 0, 0, 1, 32'h0, 32'h510, TMO, 0, 0, 0, 1, 0, 0);
      run_txn(1, 0, 0, 0, 32'h600, 32'h0, TMO - 1, 0, 0, 0, 0, 0, 1);

      // Ack while idle must not start anything.
      mem_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack", 96'({busy, mem_req, rd_valid, done}), 96'(0));

      // Reset asserted in the middle of the second read.
      start = 1'b1;
      {opnd0_rd, opnd0_wr, opnd1_rd, opnd1_wr} = 4'b1010;
      opnd0_addr = 32'h200; opnd1_addr = 32'h300;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rst_t_rd0", {63'd0, mem_req, mem_we, mem_addr}, {63'd0, 1'b1, 1'b0, 32'h200});
      mem_ack = 1'b1;
      mem_rdata = mem_peek(32'h200);
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      check("rst_t_rd1", {63'd0, mem_req, mem_we, mem_addr}, {63'd0, 1'b1, 1'b0, 32'h300});
      #2 rst = 1'b1;
      #1;
      check("rst_async_ctrl", 96'({mem_req, busy, rd_valid, done}), 96'(0));
      check("rst_async_data", {32'd0, mem_addr, opnd0_memval}, 96'(0));
      @(negedge clk);
      rst = 1'b0;
      run_txn(1, 0, 1, 0, 32'h200, 32'h300, 0, 1, 0, 0, 0, 0, 0);

      // Randomized transactions over a small address pool so collisions occur.
      for (int n = 0; n < 24; n++) begin
         ra0 = 32'h100 + 32'(4 * $urandom_range(0, 2));
         ra1 = 32'h100 + 32'(4 * $urandom_range(0, 2));
         run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ra0, ra1,
                 rnd_dly(), rnd_dly(), rnd_dly(), rnd_dly(),
                 int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
